// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers.
// Holds the stall-vector width, the stop encodings, the NOP register
// address, the all-zero data word and the stage operating-mode decode.
package pipe_pkg;

   localparam int unsigned STALL_W      = 6;
   localparam int unsigned HOLD_CNT_W   = 8;
   localparam int unsigned NOP_ADDR_W   = 5;
   localparam int unsigned WORD_W       = 32;

   localparam logic                  STOP         = 1'b1;
   localparam logic                  NOT_STOP     = 1'b0;
   localparam logic [NOP_ADDR_W-1:0] NOP_REG_ADDR = 5'd0;
   localparam logic [WORD_W-1:0]     ZEROWORD     = 32'h0000_0000;

   typedef enum logic [1:0] {
      MODE_ADVANCE = 2'd0,
      MODE_BUBBLE  = 2'd1,
      MODE_HOLD    = 2'd2
   } stage_mode_t;

   // s = this stage stopped, n = next stage stopped
   function automatic stage_mode_t stage_mode(input logic s, input logic n);
      stage_mode_t m;
      if (s == NOT_STOP)      m = MODE_ADVANCE;
      else if (n == NOT_STOP) m = MODE_BUBBLE;
      else                    m = MODE_HOLD;
      return m;
   endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async active-low), clr (sync clear, wins over inc),
//        inc (count up by one, sticks at all-ones), cnt (registered count).
module pipe_sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// One pipeline stage register with stall/bubble/hold handling and a
// multi-cycle accumulator feedback path.
// Config macro: PIPE_FLUSH_EN -- when defined, flush synchronously clears
// every output (priority over stall); otherwise flush is ignored.
// Ports: clk, rst (async active-low), stall (per-stage stop vector),
//        flush, in_* (upstream slot payload), acc_i/cnt_i (execute-unit
//        carry), out_* (registered payload), acc_o/cnt_o (carry fed back),
//        hold_cnt (consecutive stopped cycles, saturating at 255).
module pipe_stage_buf #(
   parameter int unsigned REG_DW  = 32,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned ACC_W   = 64,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned STALL_W = pipe_pkg::STALL_W,
   parameter int unsigned STAGE   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [REG_DW-1:0]  in_wdata,
   input  logic [REG_AW-1:0]  in_waddr,
   input  logic               in_wen,
   input  logic [REG_DW-1:0]  in_hi,
   input  logic [REG_DW-1:0]  in_lo,
   input  logic               in_hilo_wen,
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [CNT_W-1:0]   cnt_i,
   output logic               out_valid,
   output logic [REG_DW-1:0]  out_wdata,
   output logic [REG_AW-1:0]  out_waddr,
   output logic               out_wen,
   output logic [REG_DW-1:0]  out_hi,
   output logic [REG_DW-1:0]  out_lo,
   output logic               out_hilo_wen,
   output logic [ACC_W-1:0]   acc_o,
   output logic [CNT_W-1:0]   cnt_o,
   output logic [7:0]         hold_cnt
);

   import pipe_pkg::*;

   // Padding bit makes stall[STAGE+1] read as NOT_STOP for the last stage.
   logic [STALL_W:0] stall_ext;
   logic             s;
   logic             n;
   logic             flush_act;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             unused_bits;
   stage_mode_t      mode;

   assign stall_ext   = {NOT_STOP, stall};
   assign s           = stall_ext[STAGE];
   assign n           = stall_ext[STAGE+1];
   assign unused_bits = ^{stall_ext, flush};

`ifdef PIPE_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   always_comb begin
      mode    = stage_mode(s, n);
      cnt_clr = flush_act || (mode == MODE_ADVANCE);
      cnt_inc = (mode != MODE_ADVANCE);
   end

   // Payload and accumulator register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid    <= 1'b0;
         out_wdata    <= '0;
         out_waddr    <= '0;
         out_wen      <= 1'b0;
         out_hi       <= '0;
         out_lo       <= '0;
         out_hilo_wen <= 1'b0;
         acc_o        <= '0;
         cnt_o        <= '0;
      end else if (flush_act) begin
         out_valid    <= 1'b0;
         out_wdata    <= '0;
         out_waddr    <= '0;
         out_wen      <= 1'b0;
         out_hi       <= '0;
         out_lo       <= '0;
         out_hilo_wen <= 1'b0;
         acc_o        <= '0;
         cnt_o        <= '0;
      end else begin
         case (mode)
            MODE_ADVANCE: begin
               out_valid    <= in_valid;
               out_wdata    <= in_wdata;
               out_waddr    <= in_waddr;
               out_wen      <= in_wen & in_valid;
               out_hi       <= in_hi;
               out_lo       <= in_lo;
               out_hilo_wen <= in_hilo_wen & in_valid;
               acc_o        <= '0;
               cnt_o        <= '0;
            end
            MODE_BUBBLE: begin
               out_valid    <= 1'b0;
               out_wdata    <= REG_DW'(ZEROWORD);
               out_waddr    <= REG_AW'(NOP_REG_ADDR);
               out_wen      <= 1'b0;
               out_hi       <= REG_DW'(ZEROWORD);
               out_lo       <= REG_DW'(ZEROWORD);
               out_hilo_wen <= 1'b0;
               acc_o        <= acc_i;
               cnt_o        <= cnt_i;
            end
            default: begin
               // Hold: payload stays, execute carry keeps flowing
               acc_o        <= acc_i;
               cnt_o        <= cnt_i;
            end
         endcase
      end
   end

   pipe_sat_cnt #(
      .W (HOLD_CNT_W)
   ) u_hold_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (hold_cnt)
   );

endmodule
